// File: rtl/i2s_capture_ctrl.sv
// i2s_capture_ctrl: I2S microphone capture controller.
// Generates SCLK/WS from the master clock, deserializes left-justified SD
// words (MSB first) and offers them downstream with a sticky overflow flag.
// Build option MONO_LEFT_EN: when defined, right-channel words are dropped
// silently (no load, no overflow) and sample_chan is always 0.
//
// Output handshake: sample_valid rises with a new word and stays high, with
// sample_data/sample_chan stable, until a cycle in which sample_ready is also
// high. That cycle is the transfer; a word completing in that same cycle
// loads directly behind it.
module i2s_capture_ctrl #(
    parameter int CLK_DIV  = 75,
    parameter int SAMPLE_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    output logic                busy,
    output logic                sclk_out,
    output logic                ws_out,
    input  logic                sd_in,
    output logic [SAMPLE_W-1:0] sample_data,
    output logic                sample_chan,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                overflow,
    input  logic                clear_ovf,
    output logic [1:0]          state_dbg
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(2 * SAMPLE_W);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(2 * SAMPLE_W - 1);
    localparam logic [BIT_W-1:0] LEFT_LAST = BIT_W'(SAMPLE_W - 1);
    localparam logic [BIT_W-1:0] RIGHT_LO  = BIT_W'(SAMPLE_W);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [DIV_W-1:0]    div_ctr;
    logic [BIT_W-1:0]    bit_ctr;
    logic [SAMPLE_W-2:0] shift_q;
    logic [SAMPLE_W-1:0] word;
    logic                div_wrap;
    logic                rise_tog;
    logic                fall_tog;
    logic                frame_end;
    logic                word_done;
    logic                deliver;
    logic                out_free;

    assign busy      = (state != IDLE);
    assign state_dbg = state;
    assign ws_out    = (bit_ctr >= RIGHT_LO);

    assign div_wrap  = busy && (div_ctr == DIV_LAST);
    assign rise_tog  = div_wrap && !sclk_out;
    assign fall_tog  = div_wrap && sclk_out;
    assign frame_end = fall_tog && (bit_ctr == BIT_LAST);

    // The last bit of a word is taken straight from sd_in in its rising cycle.
    assign word      = {shift_q, sd_in};
    assign word_done = rise_tog && ((bit_ctr == LEFT_LAST) || (bit_ctr == BIT_LAST));
    assign out_free  = !sample_valid || sample_ready;

`ifdef MONO_LEFT_EN
    assign deliver = word_done && !ws_out;
`else
    assign deliver = word_done;
`endif

    // Control FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: start/stop sequencing; a stop only lands on a frame end.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_nxt = STOPPING;
                end
            end
            STOPPING: begin
                if (start) begin
                    state_nxt = RUN;
                end else if (frame_end) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // SCLK divider and bit counter; everything parks at zero while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_ctr  <= '0;
            bit_ctr  <= '0;
            sclk_out <= 1'b0;
        end else if (!busy) begin
            div_ctr  <= '0;
            bit_ctr  <= '0;
            sclk_out <= 1'b0;
        end else if (div_wrap) begin
            div_ctr  <= '0;
            sclk_out <= ~sclk_out;
            if (fall_tog) begin
                bit_ctr <= (bit_ctr == BIT_LAST) ? '0 : bit_ctr + BIT_W'(1);
            end
        end else begin
            div_ctr <= div_ctr + DIV_W'(1);
        end
    end

    // Shift sd_in into the word LSB end on every SCLK rising toggle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
        end else if (rise_tog) begin
            shift_q <= word[SAMPLE_W-2:0];
        end
    end

    // Output holding register with valid/ready handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_data  <= '0;
            sample_chan  <= 1'b0;
            sample_valid <= 1'b0;
        end else if (deliver && out_free) begin
            sample_data  <= word;
`ifdef MONO_LEFT_EN
            sample_chan  <= 1'b0;
`else
            sample_chan  <= ws_out;
`endif
            sample_valid <= 1'b1;
        end else if (sample_valid && sample_ready) begin
            sample_valid <= 1'b0;
        end
    end

    // Sticky overflow: a dropped word wins over clear_ovf in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (deliver && !out_free) begin
            overflow <= 1'b1;
        end else if (clear_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2s_capture_ctrl.sv
// Bench for i2s_capture_ctrl (CLK_DIV=4, SAMPLE_W=16).
// The reference model works from elapsed cycles since capture began: SCLK
// phase, bit index and word completion times follow from plain arithmetic.
module tb_i2s_capture_ctrl;

  localparam int CLK_DIV  = 4;
  localparam int SAMPLE_W = 16;
  localparam int FRAME    = 2 * CLK_DIV * 2 * SAMPLE_W;
`ifdef MONO_LEFT_EN
  localparam bit MONO = 1'b1;
`else
  localparam bit MONO = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic                clk;
  logic                reset;
  logic                start;
  logic                stop;
  logic                busy;
  logic                sclk_out;
  logic                ws_out;
  logic                sd_in;
  logic [SAMPLE_W-1:0] sample_data;
  logic                sample_chan;
  logic                sample_valid;
  logic                sample_ready;
  logic                overflow;
  logic                clear_ovf;
  logic [1:0]          state_dbg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  i2s_capture_ctrl #(.CLK_DIV(CLK_DIV), .SAMPLE_W(SAMPLE_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .busy         (busy),
    .sclk_out     (sclk_out),
    .ws_out       (ws_out),
    .sd_in        (sd_in),
    .sample_data  (sample_data),
    .sample_chan  (sample_chan),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overflow     (overflow),
    .clear_ovf    (clear_ovf),
    .state_dbg    (state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [SAMPLE_W-1:0] left_w;
  logic [SAMPLE_W-1:0] right_w;
  logic                rand_words;

  logic                m_busy;
  logic                m_stopping;
  int                  m_t;
  logic                m_valid;
  logic                m_chan;
  logic                m_ovf;
  logic [SAMPLE_W-1:0] m_data;

  int                  bit_idx;
  logic                m_word_chan;
  logic [SAMPLE_W-1:0] m_word;
  logic                m_word_event;
  logic                m_deliver;
  logic                m_frame_end;
  logic                m_free;
  logic                e_sclk;
  logic                e_ws;

  // Derived timing: bit index, word completion and frame end from m_t.
  always_comb begin
    bit_idx      = (m_t / (2 * CLK_DIV)) % (2 * SAMPLE_W);
    m_word_chan  = (bit_idx >= SAMPLE_W);
    m_word       = m_word_chan ? right_w : left_w;
    m_word_event = m_busy && ((m_t % (2 * CLK_DIV)) == CLK_DIV - 1)
                   && ((bit_idx % SAMPLE_W) == SAMPLE_W - 1);
    m_deliver    = m_word_event && !(MONO && m_word_chan);
    m_frame_end  = m_busy && ((m_t % FRAME) == FRAME - 1);
    m_free       = !m_valid || sample_ready;
    e_sclk       = m_busy && (((m_t / CLK_DIV) % 2) == 1);
    e_ws         = m_busy && m_word_chan;
  end

  // Model state update, one step per clock.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy     <= 1'b0;
      m_stopping <= 1'b0;
      m_t        <= 0;
      m_valid    <= 1'b0;
      m_chan     <= 1'b0;
      m_ovf      <= 1'b0;
      m_data     <= '0;
    end else begin
      if (!m_busy) begin
        if (start && !stop) begin
          m_busy     <= 1'b1;
          m_stopping <= 1'b0;
          m_t        <= 0;
        end
      end else begin
        m_t <= m_t + 1;
        if (!m_stopping) begin
          if (stop) m_stopping <= 1'b1;
        end else if (start) begin
          m_stopping <= 1'b0;
        end else if (m_frame_end) begin
          m_busy     <= 1'b0;
          m_stopping <= 1'b0;
          m_t        <= 0;
        end
      end
      if (m_deliver && m_free) begin
        m_valid <= 1'b1;
        m_data  <= m_word;
        m_chan  <= m_word_chan;
      end else if (m_valid && sample_ready) begin
        m_valid <= 1'b0;
      end
      if (m_deliver && !m_free) m_ovf <= 1'b1;
      else if (clear_ovf) m_ovf <= 1'b0;
    end
  end

  // Microphone: present the bit of the current word for the model's bit slot.
  initial begin : mic_drv
    logic [SAMPLE_W-1:0] w;
    int bi;
    sd_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rand_words && m_busy && ((m_t % FRAME) == 0)) begin
        left_w  = SAMPLE_W'($urandom);
        right_w = SAMPLE_W'($urandom);
      end
      bi = (m_t / (2 * CLK_DIV)) % (2 * SAMPLE_W);
      w  = (bi >= SAMPLE_W) ? right_w : left_w;
      sd_in = m_busy ? w[SAMPLE_W - 1 - (bi % SAMPLE_W)] : 1'($urandom_range(0, 1));
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    check("busy", busy, m_busy);
    check("state_dbg_busy", state_dbg != 2'd0, m_busy);
    check("sclk_out", sclk_out, e_sclk);
    check("ws_out", ws_out, e_ws);
    check("sample_valid", sample_valid, m_valid);
    check("overflow", overflow, m_ovf);
    if (m_valid) begin
      check("sample_data", sample_data, m_data);
      check("sample_chan", sample_chan, m_chan);
    end
  end

  // ---------------- scoreboard for directed words ----------------
  logic [SAMPLE_W:0] exp_q[$];
  logic              sb_en;
  int                vcount;

  always @(negedge clk) begin
    if (sb_en) begin
      if (sample_valid) vcount++;
      if (sample_valid && sample_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_word", {sample_chan, sample_data}, 17'h1ffff);
        end else begin
          check("sb_word", {sample_chan, sample_data}, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
  endtask

  task automatic wait_phase(input int ph);
    int n = 0;
    while (!(m_busy && ((m_t % FRAME) == ph)) && n < 2000) begin
      tick();
      n++;
    end
    check("wait_phase_bound", n < 2000, 1'b1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin
      tick();
      n++;
    end
    check("wait_idle_bound", n < 2000, 1'b1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int n;
    int rmode;
    logic [SAMPLE_W-1:0] got_right;

    reset        = 1'b1;
    start        = 1'b0;
    stop         = 1'b0;
    sample_ready = 1'b1;
    clear_ovf    = 1'b0;
    rand_words   = 1'b0;
    sb_en        = 1'b0;
    vcount       = 0;
    left_w       = 16'hA5C3;
    right_w      = 16'h1234;
    repeat (3) tick();
    check("rst_busy", busy, 1'b0);
    check("rst_sclk", sclk_out, 1'b0);
    check("rst_ws", ws_out, 1'b0);
    check("rst_data", sample_data, 16'h0000);
    check("rst_valid", sample_valid, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    reset = 1'b0;
    repeat (5) tick();

    // start and stop together while idle: stop wins
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    tick();
    check("start_stop_idle", busy, 1'b0);

    // Data + timing
    exp_q.push_back({1'b0, 16'hA5C3});
`ifndef MONO_LEFT_EN
    exp_q.push_back({1'b1, 16'h1234});
`endif
    sb_en = 1'b1;
    pulse_start();
    check("busy_after_start", busy, 1'b1);
    n = 0;
    while (!sclk_out && n < 50) begin tick(); n++; end
    check("first_rise_delay", n, 4);
    n = 0;
    while (sclk_out && n < 50) begin tick(); n++; end
    while (!sclk_out && n < 50) begin tick(); n++; end
    check("sclk_period", n, 8);
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin tick(); n++; end
    check("data_drain", exp_q.size(), 0);
    sb_en = 1'b0;
    check("valid_cycles", vcount, MONO ? 1 : 2);
    check("data_ovf", overflow, 1'b0);

    // frame length from WS rise to rise
    n = 0;
    while (ws_out && n < 600) begin tick(); n++; end
    while (!ws_out && n < 600) begin tick(); n++; end
    n = 0;
    while (ws_out && n < 600) begin tick(); n++; end
    while (!ws_out && n < 600) begin tick(); n++; end
    check("ws_frame_len", n, 256);

    // Backpressure for a full frame
    wait_phase(0);
    sample_ready = 1'b0;
    wait_phase(255);
    tick();
    check("bp_valid_held", sample_valid, 1'b1);
    check("bp_data_held", sample_data, 16'hA5C3);
    check("bp_chan_held", sample_chan, 1'b0);
    check("bp_ovf", overflow, !MONO);
    sample_ready = 1'b1;
    tick();
    check("bp_one_transfer", sample_valid, 1'b0);
    pulse_clear();
    check("ovf_cleared", overflow, 1'b0);

    // clear_ovf in the same cycle as a drop
    wait_phase(0);
    sample_ready = 1'b0;
    wait_phase(251);
    pulse_clear();
    check("ovf_set_beats_clear", overflow, !MONO);
    sample_ready = 1'b1;
    tick();
    pulse_clear();

    // Stop mid-frame at bit 5
    got_right = '0;
    wait_phase(40);
    pulse_stop();
    n = 0;
    while (busy && n < 600) begin
      if (sample_valid && sample_chan) got_right = sample_data;
      tick();
      n++;
    end
    check("stop_to_idle", n, 215);
    check("stop_right_word", got_right, MONO ? 16'h0000 : 16'h1234);
    check("stop_sclk_low", sclk_out, 1'b0);
    check("stop_ws_low", ws_out, 1'b0);

    // start during STOPPING keeps capturing
    pulse_start();
    wait_phase(40);
    pulse_stop();
    wait_phase(100);
    pulse_start();
    wait_phase(10);
    check("restart_no_gap", busy, 1'b1);
    pulse_stop();
    wait_idle();

    // Randomized traffic
    rand_words = 1'b1;
    rmode = 2;
    for (int c = 0; c < 6000; c++) begin
      if (c % 400 == 0) rmode = $urandom_range(0, 2);
      sample_ready = (rmode == 0) ? 1'b0 : (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      clear_ovf    = ($urandom_range(0, 63) == 0);
      start        = ($urandom_range(0, 299) == 0);
      stop         = ($urandom_range(0, 399) == 0);
      tick();
    end
    start        = 1'b0;
    stop         = 1'b0;
    clear_ovf    = 1'b0;
    sample_ready = 1'b1;
    repeat (3) tick();

    // Asynchronous reset mid-run with a held word
    sample_ready = 1'b0;
    pulse_start();
    wait_phase(133);
    #1;
    reset = 1'b1;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_sclk", sclk_out, 1'b0);
    check("arst_ws", ws_out, 1'b0);
    check("arst_data", sample_data, 16'h0000);
    check("arst_chan", sample_chan, 1'b0);
    check("arst_valid", sample_valid, 1'b0);
    check("arst_ovf", overflow, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    sample_ready = 1'b1;
    repeat (300) tick();
    check("post_rst_valid", sample_valid, 1'b0);
    check("post_rst_busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
